// File: rtl/tlb_write_unit.sv
// TLB entry array with TLBWI/TLBWR write path, CP0 Random/Wired upkeep and a TLBR read port.
// Optional TLBP compare logic is built when the macro TLB_PROBE_EN is defined.
module tlb_write_unit #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int WIRED_ADDR  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlbwi_i,
  input  logic             tlbwr_i,
  input  logic [31:0]      index_i,
  input  logic [31:0]      entryhi_i,
  input  logic [31:0]      entrylo0_i,
  input  logic [31:0]      entrylo1_i,
  input  logic             write_cp0_i,
  input  logic [4:0]       write_cp0_addr_i,
  input  logic [31:0]      write_cp0_data_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [31:0]      rd_entryhi_o,
  output logic [31:0]      rd_entrylo0_o,
  output logic [31:0]      rd_entrylo1_o,
  output logic [31:0]      random_o,
  output logic [31:0]      wired_o,
  output logic             tlbw_done_o,
  output logic             probe_hit_o,
  output logic [IDX_W-1:0] probe_idx_o
);

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);

  logic [18:0]      vpn2_q [TLB_ENTRIES];
  logic [7:0]       asid_q [TLB_ENTRIES];
  logic             g_q    [TLB_ENTRIES];
  logic [24:0]      lo0_q  [TLB_ENTRIES];
  logic [24:0]      lo1_q  [TLB_ENTRIES];
  logic [IDX_W-1:0] random_q, random_d;
  logic [IDX_W-1:0] wired_q, wired_d;
  logic             done_q;
  logic             we_s;
  logic             wired_wr_s;
  logic [IDX_W-1:0] waddr_s;
  logic             unused_ok_s;

  assign we_s       = tlbwi_i | tlbwr_i;
  // TLBWI has priority; Random is the value held before this edge's update.
  assign waddr_s    = tlbwi_i ? index_i[IDX_W-1:0] : random_q;
  assign wired_wr_s = write_cp0_i && (write_cp0_addr_i == 5'(WIRED_ADDR));

  always_comb begin
    random_d = random_q;
    wired_d  = wired_q;
    if (wired_wr_s) begin
      random_d = RAND_MAX;
      wired_d  = write_cp0_data_i[IDX_W-1:0];
    end else if (random_q <= wired_q) begin
      random_d = RAND_MAX;
    end else begin
      random_d = random_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        vpn2_q[i] <= 19'd0;
        asid_q[i] <= 8'd0;
        g_q[i]    <= 1'b0;
        lo0_q[i]  <= 25'd0;
        lo1_q[i]  <= 25'd0;
      end
      random_q <= RAND_MAX;
      wired_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired_d;
      done_q   <= we_s;
      if (we_s) begin
        vpn2_q[waddr_s] <= entryhi_i[31:13];
        asid_q[waddr_s] <= entryhi_i[7:0];
        g_q[waddr_s]    <= entrylo0_i[0] & entrylo1_i[0];
        lo0_q[waddr_s]  <= entrylo0_i[25:1];
        lo1_q[waddr_s]  <= entrylo1_i[25:1];
      end
    end
  end

  assign rd_entryhi_o  = {vpn2_q[rd_idx_i], 5'b0_0000, asid_q[rd_idx_i]};
  assign rd_entrylo0_o = {6'b00_0000, lo0_q[rd_idx_i], g_q[rd_idx_i]};
  assign rd_entrylo1_o = {6'b00_0000, lo1_q[rd_idx_i], g_q[rd_idx_i]};
  assign random_o      = {{(32-IDX_W){1'b0}}, random_q};
  assign wired_o       = {{(32-IDX_W){1'b0}}, wired_q};
  assign tlbw_done_o   = done_q;

`ifdef TLB_PROBE_EN
  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    probe_hit_o = 1'b0;
    probe_idx_o = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if ((vpn2_q[i] == entryhi_i[31:13]) &&
          (g_q[i] || (asid_q[i] == entryhi_i[7:0]))) begin
        probe_hit_o = 1'b1;
        probe_idx_o = IDX_W'(i);
      end else begin
        probe_hit_o = probe_hit_o;
      end
    end
  end
`else
  assign probe_hit_o = 1'b0;
  assign probe_idx_o = '0;
`endif

  assign unused_ok_s = &{1'b0, index_i[31:IDX_W], entryhi_i[12:8], entrylo0_i[31:26],
                         entrylo1_i[31:26], write_cp0_data_i[31:IDX_W]};

endmodule
